// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
//
// Purpose:
//   Command sequencer that sits behind the UART receiver. It parses the
//   fixed-format frames SYNC, CMD, ADDR, [DATA], CSUM. For each valid frame it
//   issues one single-beat transaction on a simple req/ack register bus. Read
//   data is returned on a valid/ready response port. Inter-byte timeouts, bus
//   timeouts, unknown commands and checksum mismatches abort the frame, so the
//   register bus never sees a partial or corrupt command.
//
// Ports:
//   sys_clk     in   system clock
//   sys_rst_n   in   synchronous active-low reset
//   uart_rec    in   receiver done flag; a rising edge marks a new byte
//   uart_data   in   received byte, valid in the cycle uart_rec rises
//   bus_req     out  transaction request, held until ack or bus timeout
//   bus_we      out  1 = write, 0 = read
//   bus_addr    out  register address
//   bus_wdata   out  write data
//   bus_rdata   in   read data, valid together with bus_ack on a read
//   bus_ack     in   single-cycle transaction acknowledge
//   rsp_valid   out  read response available
//   rsp_data    out  read response byte
//   rsp_ready   in   response consumer accept
//   frame_ok    out  one-cycle pulse when a command completes
//   frame_err   out  one-cycle pulse when a frame is aborted
//   err_code    out  1 = bad cmd, 2 = checksum, 3 = timeout (held until the
//                    next frame_err)
// ---------------------------------------------------------------------------
module uart_cmd_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'h55,
    parameter int         BYTE_TIMEOUT = 2500,
    parameter int         BUS_TIMEOUT  = 255
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rec,
    input  logic [7:0] uart_data,
    output logic       bus_req,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       bus_ack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       rsp_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    localparam logic [1:0] ERR_CMD     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Counter widths sized so the terminal count (TIMEOUT-1) always fits.
    localparam int BYTE_CW = $clog2(BYTE_TIMEOUT + 1);
    localparam int BUS_CW  = $clog2(BUS_TIMEOUT + 1);

    localparam logic [BYTE_CW-1:0] BYTE_LAST = BYTE_CW'(BYTE_TIMEOUT - 1);
    localparam logic [BUS_CW-1:0]  BUS_LAST  = BUS_CW'(BUS_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CSUM,
        ST_BUS,
        ST_RSP
    } state_t;

    state_t              state_q,     state_d;
    logic                rec_d_q;
    logic                is_wr_q,     is_wr_d;
    logic [7:0]          sum_q,       sum_d;
    logic [7:0]          bus_addr_q,  bus_addr_d;
    logic [7:0]          bus_wdata_q, bus_wdata_d;
    logic                bus_req_q,   bus_req_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [7:0]          rsp_data_q,  rsp_data_d;
    logic                frame_ok_q,  frame_ok_d;
    logic                frame_err_q, frame_err_d;
    logic [1:0]          err_code_q,  err_code_d;
    logic [BYTE_CW-1:0]  byte_cnt_q,  byte_cnt_d;
    logic [BUS_CW-1:0]   bus_cnt_q,   bus_cnt_d;

    logic byte_stb;

    // The receiver flag may stay high for several cycles; only its rising
    // edge denotes a new byte.
    assign byte_stb = uart_rec & ~rec_d_q;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        sum_d       = sum_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_req_d   = bus_req_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        byte_cnt_d  = byte_cnt_q;
        bus_cnt_d   = bus_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                // Anything other than the sync marker is line noise.
                if (byte_stb && (uart_data == SYNC_BYTE)) begin
                    state_d    = ST_CMD;
                    byte_cnt_d = '0;
                end
            end

            ST_CMD, ST_ADDR, ST_DATA, ST_CSUM: begin
                // A byte arriving in the terminal cycle beats the timeout.
                if (byte_stb) begin
                    byte_cnt_d = '0;
                    unique case (state_q)
                        ST_CMD: begin
                            if ((uart_data == CMD_WR) || (uart_data == CMD_RD)) begin
                                is_wr_d = (uart_data == CMD_WR);
                                sum_d   = uart_data;
                                state_d = ST_ADDR;
                            end else begin
                                frame_err_d = 1'b1;
                                err_code_d  = ERR_CMD;
                                state_d     = ST_IDLE;
                            end
                        end
                        ST_ADDR: begin
                            bus_addr_d = uart_data;
                            sum_d      = sum_q + uart_data;
                            state_d    = is_wr_q ? ST_DATA : ST_CSUM;
                        end
                        ST_DATA: begin
                            bus_wdata_d = uart_data;
                            sum_d       = sum_q + uart_data;
                            state_d     = ST_CSUM;
                        end
                        default: begin
                            if (uart_data == sum_q) begin
                                bus_req_d = 1'b1;
                                bus_cnt_d = '0;
                                state_d   = ST_BUS;
                            end else begin
                                frame_err_d = 1'b1;
                                err_code_d  = ERR_CSUM;
                                state_d     = ST_IDLE;
                            end
                        end
                    endcase
                end else if (byte_cnt_q == BYTE_LAST) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    byte_cnt_d  = '0;
                    state_d     = ST_IDLE;
                end else begin
                    byte_cnt_d = byte_cnt_q + BYTE_CW'(1);
                end
            end

            ST_BUS: begin
                // Received bytes are dropped here; an ack in the last
                // timeout cycle still completes the transaction.
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    bus_cnt_d = '0;
                    if (is_wr_q) begin
                        frame_ok_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        rsp_data_d  = bus_rdata;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RSP;
                    end
                end else if (bus_cnt_q == BUS_LAST) begin
                    bus_req_d   = 1'b0;
                    bus_cnt_d   = '0;
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = ST_IDLE;
                end else begin
                    bus_cnt_d = bus_cnt_q + BUS_CW'(1);
                end
            end

            ST_RSP: begin
                // Waits indefinitely for the consumer; received bytes dropped.
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    frame_ok_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            rec_d_q     <= 1'b0;
            is_wr_q     <= 1'b0;
            sum_q       <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_req_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            byte_cnt_q  <= '0;
            bus_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rec_d_q     <= uart_rec;
            is_wr_q     <= is_wr_d;
            sum_q       <= sum_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_req_q   <= bus_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            byte_cnt_q  <= byte_cnt_d;
            bus_cnt_q   <= bus_cnt_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = is_wr_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;

endmodule
